// File: rtl/debug_pkg.sv
// Shared definitions for the debug frame transmitter.
//   state_t           : FSM state encoding, also exported on state_dbg
//   DEFAULT_SYNC_BYTE : header byte that precedes every frame
//   clog2()           : ceiling log2, used to size the byte index counter
package debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ISSUE  = 2'b01,
        ST_HOLD   = 2'b10,
        ST_FINISH = 2'b11
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/frame_byte_mux.sv
// Combinational byte selector for the frame sequence.
//   snapshot : captured payload, FRAME_BYTES*8 bits
//   index    : position in the frame (0 = sync, 1..FRAME_BYTES = payload,
//              FRAME_BYTES+1 = checksum)
//   checksum : running payload sum, only selected past the payload
//   byte_out : byte at the given index
module frame_byte_mux
    import debug_pkg::*;
#(
    parameter int         FRAME_BYTES = 215,
    parameter int         IDX_W       = 8,
    parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
    parameter int         MSB_FIRST   = 1
) (
    input  logic [FRAME_BYTES*8-1:0] snapshot,
    input  logic [IDX_W-1:0]         index,
    input  logic [7:0]               checksum,
    output logic [7:0]               byte_out
);

    always_comb begin
        int k;
        int pos;
        k        = int'(index) - 1;
        // Byte lane inside the snapshot holding payload byte k.
        pos      = (MSB_FIRST != 0) ? (FRAME_BYTES - 1 - k) : k;
        byte_out = 8'h00;
        if (index == '0) begin
            byte_out = SYNC_BYTE;
        end else if (int'(index) <= FRAME_BYTES) begin
            for (int i = 0; i < FRAME_BYTES; i++) begin
                if (pos == i) byte_out = snapshot[i*8 +: 8];
            end
        end else begin
            byte_out = checksum;
        end
    end

endmodule

// File: rtl/debug_frame_tx.sv
// Frame transmitter feeding a byte-wide UART: sends SYNC_BYTE, the captured
// payload and an optional 8-bit additive checksum, one byte per ISSUE/HOLD
// pair, stalling while the UART reports busy.
//   clk, reset  : clock, asynchronous active-high reset
//   send        : start request, honoured in IDLE only
//   frame_data  : payload, snapshotted when send is accepted
//   tx_busy     : UART busy, a byte is only issued while it is low
//   wr_uart     : one-cycle write strobe, w_data valid with it (else 0)
//   busy        : high whenever not IDLE
//   done        : one-cycle pulse in FINISH
//   state_dbg   : current state encoding
module debug_frame_tx
    import debug_pkg::*;
#(
    parameter int         FRAME_BYTES  = 215,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int         ADD_CHECKSUM = 1,
    parameter int         MSB_FIRST    = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     send,
    input  logic [FRAME_BYTES*8-1:0] frame_data,
    input  logic                     tx_busy,
    output logic                     wr_uart,
    output logic [7:0]               w_data,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               state_dbg
);

    localparam int TOTAL = 1 + FRAME_BYTES + ((ADD_CHECKSUM != 0) ? 1 : 0);
    localparam int IDX_W = clog2(TOTAL + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

    state_t                   state;
    logic [IDX_W-1:0]         index;
    logic [7:0]               checksum;
    logic [FRAME_BYTES*8-1:0] snapshot;
    logic [7:0]               mux_byte;
    logic                     is_payload;

    frame_byte_mux #(
        .FRAME_BYTES (FRAME_BYTES),
        .IDX_W       (IDX_W),
        .SYNC_BYTE   (SYNC_BYTE),
        .MSB_FIRST   (MSB_FIRST)
    ) u_mux (
        .snapshot (snapshot),
        .index    (index),
        .checksum (checksum),
        .byte_out (mux_byte)
    );

    // Strobe is decoded straight from state so reset kills it immediately.
    assign wr_uart    = (state == ST_ISSUE) && !tx_busy;
    assign w_data     = wr_uart ? mux_byte : 8'h00;
    assign state_dbg  = state;
    assign is_payload = (index != '0) && (int'(index) <= FRAME_BYTES);

    // Payload snapshot carries no reset; it is always rewritten before use.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && send) snapshot <= frame_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            index    <= '0;
            checksum <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (send) begin
                        index    <= '0;
                        checksum <= 8'h00;
                        busy     <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!tx_busy) begin
                        if (is_payload) checksum <= checksum + mux_byte;
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (index == LAST_IDX) begin
                        done  <= 1'b1;
                        state <= ST_FINISH;
                    end else begin
                        index <= index + 1'b1;
                        state <= ST_ISSUE;
                    end
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_frame_tx.sv
// Bench for debug_frame_tx: four instances (4-byte MSB/LSB first, 2-byte with
// and without checksum) share send/tx_busy/reset and are checked together.
module tb_debug_frame_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        send = 1'b0;
    logic        tx_busy = 1'b0;
    logic [31:0] fd4 = 32'h0;
    logic [15:0] fd2 = 16'h0;

    logic       wr   [4];
    logic [7:0] wd   [4];
    logic       bsy  [4];
    logic       dn   [4];
    logic [1:0] st   [4];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int send_cyc = 0;

    logic [7:0] q0[$], q1[$], q2[$], q3[$];
    int         ts0[$];
    int         dc[4];
    int         dstamp[4];

    typedef struct {
        logic [31:0] d4;
        logic [15:0] d2;
        logic [47:0] ea;   // FRAME_BYTES=4, MSB first, checksum
        logic [47:0] eb;   // FRAME_BYTES=4, LSB first, checksum
        logic [31:0] ec;   // FRAME_BYTES=2, MSB first, checksum
        logic [23:0] ed;   // FRAME_BYTES=2, MSB first, no checksum
    } vec_t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    debug_frame_tx #(.FRAME_BYTES(4), .SYNC_BYTE(8'hA5), .ADD_CHECKSUM(1), .MSB_FIRST(1)) u_a (
        .clk(clk), .reset(reset), .send(send), .frame_data(fd4), .tx_busy(tx_busy),
        .wr_uart(wr[0]), .w_data(wd[0]), .busy(bsy[0]), .done(dn[0]), .state_dbg(st[0]));
    debug_frame_tx #(.FRAME_BYTES(4), .SYNC_BYTE(8'hA5), .ADD_CHECKSUM(1), .MSB_FIRST(0)) u_b (
        .clk(clk), .reset(reset), .send(send), .frame_data(fd4), .tx_busy(tx_busy),
        .wr_uart(wr[1]), .w_data(wd[1]), .busy(bsy[1]), .done(dn[1]), .state_dbg(st[1]));
    debug_frame_tx #(.FRAME_BYTES(2), .SYNC_BYTE(8'hA5), .ADD_CHECKSUM(1), .MSB_FIRST(1)) u_c (
        .clk(clk), .reset(reset), .send(send), .frame_data(fd2), .tx_busy(tx_busy),
        .wr_uart(wr[2]), .w_data(wd[2]), .busy(bsy[2]), .done(dn[2]), .state_dbg(st[2]));
    debug_frame_tx #(.FRAME_BYTES(2), .SYNC_BYTE(8'hA5), .ADD_CHECKSUM(0), .MSB_FIRST(1)) u_d (
        .clk(clk), .reset(reset), .send(send), .frame_data(fd2), .tx_busy(tx_busy),
        .wr_uart(wr[3]), .w_data(wd[3]), .busy(bsy[3]), .done(dn[3]), .state_dbg(st[3]));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Outputs are sampled mid-cycle; inputs change 1 time unit after posedge.
    always @(negedge clk) begin
        if (wr[0]) begin q0.push_back(wd[0]); ts0.push_back(cyc); end
        if (wr[1]) q1.push_back(wd[1]);
        if (wr[2]) q2.push_back(wd[2]);
        if (wr[3]) q3.push_back(wd[3]);
        for (int i = 0; i < 4; i++) begin
            if (!wr[i]) check("w_data_zero_when_idle", 32'(wd[i]), 32'h0);
            if (dn[i]) begin
                dc[i]++;
                dstamp[i] = cyc;
                check("done_in_finish", 32'(st[i]), 32'h3);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        q0.delete(); q1.delete(); q2.delete(); q3.delete(); ts0.delete();
        for (int i = 0; i < 4; i++) begin dc[i] = 0; dstamp[i] = 0; end
    endtask

    function automatic bit all_busy();
        return bsy[0] && bsy[1] && bsy[2] && bsy[3];
    endfunction

    function automatic bit any_busy();
        return bsy[0] || bsy[1] || bsy[2] || bsy[3];
    endfunction

    // Pulse send, then run until every instance is back in IDLE.
    task automatic run_frame(input logic [31:0] a, input logic [15:0] c,
                             input bit rnd_busy, input bit chaos);
        int n;
        clear_all();
        fd4 = a; fd2 = c; tx_busy = 1'b0; send = 1'b1;
        send_cyc = cyc;
        step();
        send = 1'b0;
        check("busy_after_send", 32'(bsy[0]), 32'h1);
        for (n = 0; n < 3000; n++) begin
            if (!any_busy()) break;
            tx_busy = rnd_busy ? ($urandom_range(2) == 0) : 1'b0;
            if (chaos) begin
                fd4  = $urandom;
                fd2  = 16'($urandom);
                send = all_busy() && ($urandom_range(3) == 0);
            end
            step();
        end
        send = 1'b0; tx_busy = 1'b0;
        check("frame_completes_in_budget", 32'(n < 3000), 32'h1);
        for (int i = 0; i < 4; i++) check("done_pulse_count", 32'(dc[i]), 32'h1);
    endtask

    task automatic cmp_packed(input string nm, input logic [7:0] got[$],
                              input logic [47:0] exp, input int n);
        check({nm, "_len"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < got.size(); i++)
            check(nm, 32'(got[i]), 32'(exp[(n-1-i)*8 +: 8]));
    endtask

    // Reference: sync, payload bytes in chosen order, optional sum mod 256.
    task automatic cmp_model(input string nm, input logic [7:0] got[$], input logic [31:0] d,
                             input int fb, input int msb, input int ck);
        logic [7:0] exp[$];
        int sum;
        sum = 0;
        exp.push_back(8'hA5);
        for (int k = 0; k < fb; k++) begin
            logic [7:0] b;
            b = (msb != 0) ? d[(fb-1-k)*8 +: 8] : d[k*8 +: 8];
            sum = sum + int'(b);
            exp.push_back(b);
        end
        if (ck != 0) exp.push_back(8'(sum % 256));
        check({nm, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check(nm, 32'(got[i]), 32'(exp[i]));
    endtask

    task automatic cmp_row(input vec_t v);
        cmp_packed("row_a_msb", q0, v.ea, 6);
        cmp_packed("row_b_lsb", q1, v.eb, 6);
        cmp_packed("row_c_fb2", q2, {16'h0, v.ec}, 4);
        cmp_packed("row_d_nock", q3, {24'h0, v.ed}, 3);
    endtask

    initial begin
        vec_t vt[4];
        int   n;
        int   rel;

        vt[0] = '{32'h01020304, 16'hFF02, 48'hA5_01_02_03_04_0A, 48'hA5_04_03_02_01_0A, 32'hA5_FF_02_01, 24'hA5_FF_02};
        vt[1] = '{32'h80FF7F01, 16'h0000, 48'hA5_80_FF_7F_01_FF, 48'hA5_01_7F_FF_80_FF, 32'hA5_00_00_00, 24'hA5_00_00};
        vt[2] = '{32'h00000000, 16'h1234, 48'hA5_00_00_00_00_00, 48'hA5_00_00_00_00_00, 32'hA5_12_34_46, 24'hA5_12_34};
        vt[3] = '{32'hFFFFFFFF, 16'hFFFF, 48'hA5_FF_FF_FF_FF_FC, 48'hA5_FF_FF_FF_FF_FC, 32'hA5_FF_FF_FE, 24'hA5_FF_FF};

        // Reset state
        #1 reset = 1'b1;
        #2;
        for (int i = 0; i < 4; i++) begin
            check("reset_wr_uart", 32'(wr[i]), 32'h0);
            check("reset_busy", 32'(bsy[i]), 32'h0);
            check("reset_done", 32'(dn[i]), 32'h0);
            check("reset_state", 32'(st[i]), 32'h0);
        end
        step(); step();
        reset = 1'b0;
        step();

        // Table vectors, tx_busy held low
        for (int r = 0; r < 4; r++) begin
            run_frame(vt[r].d4, vt[r].d2, 1'b0, 1'b0);
            cmp_row(vt[r]);
            if (r == 0) begin
                check("sync_first_cycle", 32'(ts0.size() > 0 ? ts0[0] : -1), 32'(send_cyc + 1));
                check("strobe_count_a", 32'(ts0.size()), 32'h6);
                for (int i = 1; i < ts0.size(); i++)
                    check("byte_spacing", 32'(ts0[i] - ts0[i-1]), 32'h2);
                check("done_after_last", 32'(dstamp[0]), 32'(ts0.size() > 0 ? ts0[ts0.size()-1] + 2 : -1));
            end
            step();
        end

        // UART busy stall after sync, with mid-frame send and data churn
        clear_all();
        fd4 = 32'h01020304; fd2 = 16'hFF02; send = 1'b1;
        step();
        send = 1'b0;
        for (n = 0; n < 50 && q0.size() < 1; n++) step();
        check("stall_sync_seen", 32'(q0.size()), 32'h1);
        tx_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            fd4  = $urandom;
            fd2  = 16'($urandom);
            send = (i % 3 == 0);
            step();
        end
        send = 1'b0;
        check("no_strobe_while_busy", 32'(q0.size()), 32'h1);
        tx_busy = 1'b0;
        rel = cyc;
        step();
        check("issue_on_busy_release", 32'(ts0.size() > 1 ? ts0[1] : -1), 32'(rel));
        for (n = 0; n < 100 && any_busy(); n++) step();
        check("stall_frame_completes", 32'(n < 100), 32'h1);
        cmp_row(vt[0]);
        step();

        // Reset mid-frame, on the third byte's strobe
        clear_all();
        fd4 = 32'h01020304; fd2 = 16'hFF02; send = 1'b1;
        step();
        send = 1'b0;
        for (n = 0; n < 50 && q0.size() < 2; n++) step();
        step();
        check("strobe_before_reset", 32'(wr[0]), 32'h1);
        reset = 1'b1;
        #1;
        check("reset_kills_strobe", 32'(wr[0]), 32'h0);
        check("reset_kills_wdata", 32'(wd[0]), 32'h0);
        check("reset_clears_busy", 32'(bsy[0]), 32'h0);
        check("reset_state_idle", 32'(st[0]), 32'h0);
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("no_strobe_after_abort", 32'(q0.size()), 32'h2);
        check("idle_after_abort", 32'(bsy[1]), 32'h0);
        run_frame(32'h01020304, 16'hFF02, 1'b0, 1'b0);
        cmp_row(vt[0]);
        step();

        // Randomized frames against the reference model
        for (int it = 0; it < 8; it++) begin
            logic [31:0] a;
            logic [15:0] c;
            a = $urandom;
            c = 16'($urandom);
            run_frame(a, c, 1'b1, 1'b1);
            cmp_model("rnd_a", q0, a, 4, 1, 1);
            cmp_model("rnd_b", q1, a, 4, 0, 1);
            cmp_model("rnd_c", q2, {16'h0, c}, 2, 1, 1);
            cmp_model("rnd_d", q3, {16'h0, c}, 2, 1, 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
